run_event_counter: RTL and testbench
====================================

# run_event_counter

Windowed event accumulator that sits directly downstream of the 111/000 Mealy run detector. It takes the detector's input bit and its same-cycle detection pulse, and classifies each pulse as a ones-run (111) or zeros-run (000) event. Both event types are counted over fixed-length bit windows. Each closed window's counts go to a downstream consumer over a valid/ready report port with explicit loss signalling.

## Interface
- CW, 8, width of each event counter and report count field
- WIN_W, 9, width of the window bit counter and of rpt_len
- WINDOW, 300, bits per full window; legal range 1..2^WIN_W-1
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- en  input  1  bit-cycle qualifier; bit_in/det_in sampled only when en=1
- bit_in  input  1  serial bit presented to the detector this cycle
- det_in  input  1  detector Mealy output for the same cycle
- flush  input  1  close current window early (partial report)
- rpt_ready  input  1  consumer accepts report
- rpt_valid  output  1  report holding register full
- ones_cnt  output  CW  111 events in reported window
- zeros_cnt  output  CW  000 events in reported window
- rpt_len  output  WIN_W  bit cycles in reported window
- drop  output  1  sticky: at least one window report lost
- busy  output  1  FSM in RUN

## Operation
- Bit cycle: a cycle with en=1. Event classification on bit cycles: det_in=1 & bit_in=1 -> ones event; det_in=1 & bit_in=0 -> zeros event; det_in=0 -> none. det_in is ignored when en=0.
- FSM states: IDLE, RUN.
  - IDLE -> RUN on the first bit cycle; that cycle counts as bit 1.
  - In IDLE, flush is ignored.
  - RUN -> IDLE on flush; RUN stays in RUN on a full-window close.
- Accumulators ones_acc/zeros_acc saturate at 2^CW-1 and never wrap. bit_cnt counts bit cycles in the current window.
- Full close: the bit cycle where bit_cnt reaches WINDOW. Report = accumulators including this cycle's event, rpt_len=WINDOW. Accumulators and bit_cnt clear to 0.
- Flush close (RUN, flush=1):
  - Report = counts so far, including the event of the current cycle if en=1; rpt_len = bits so far.
  - If flush coincides with a bit cycle that is exactly bit WINDOW, it is a single close with rpt_len=WINDOW; the FSM still goes to IDLE.
  - If bits so far = 0 (flush immediately after a full close with en=0), no report is produced; the FSM goes to IDLE.
- Report handshake:
  - rpt_valid rises the cycle after a close. ones_cnt/zeros_cnt/rpt_len are held stable while rpt_valid=1.
  - A transfer occurs when rpt_valid & rpt_ready; rpt_valid falls next cycle unless a new close occurs in the same cycle, in which case the new report loads and rpt_valid stays 1.
  - Close while rpt_valid=1 & rpt_ready=0: the new report is discarded, the held report is unchanged, and drop is set.
- drop clears only on rst.
- Reset (any time, including mid-window or with a report pending): state=IDLE; all counters, report fields, rpt_valid, drop, and busy = 0. A pending report is lost without setting drop.

## Timing
- Accumulator update: one cycle after the bit cycle.
- Close-to-rpt_valid latency: 1 cycle.
- busy = (state==RUN), registered.
- No combinational path from inputs to outputs. rpt_valid does not depend on rpt_ready.

## Structure
- Package run_evt_pkg: state enum {IDLE, RUN} and event-type constants EV_NONE/EV_ONES/EV_ZEROS.
- Sub-module sat_counter (parameter W; inputs inc, clr; saturating). Instantiated twice for the ones and zeros accumulators.

## Test plan
- WINDOW=16; en=1. Stream 1111 0000 10101010 with det_in from the detector model (pulses on bits 3, 4, 7, 8) -> the cycle after bit 16: rpt_valid=1, ones_cnt=2, zeros_cnt=2, rpt_len=16.
- Default params; 300 bits of all ones (298 events) -> ones_cnt=255 (saturated), zeros_cnt=0, rpt_len=300.
- WINDOW=16; rpt_ready=0 through two full windows -> first report held unchanged, drop=1 after the second close. Then rpt_ready=1 -> one transfer, rpt_valid=0.
- WINDOW=16; rpt_ready=1 exactly on the cycle of the second close -> second report loads, rpt_valid stays 1, drop=0.
- Bits 11100 with en=1, then flush=1 with en=0 -> report ones_cnt=1, zeros_cnt=0, rpt_len=5; busy=0 next cycle. A second flush -> no report.
- rst pulse while rpt_valid=1 and mid-window -> all outputs 0 on the next edge. The next full window reports fresh counts only.

Source files
------------

// File: rtl/run_evt_pkg.sv
// Shared types for the run event counter: FSM state encoding and event classes.
package run_evt_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    typedef logic [1:0] ev_t;

    localparam ev_t EV_NONE  = 2'd0;
    localparam ev_t EV_ONES  = 2'd1;
    localparam ev_t EV_ZEROS = 2'd2;

    // A detector pulse is a ones-run when the bit that completed it is 1.
    function automatic ev_t classify(input logic det, input logic bit_v);
        ev_t ev;
        ev = EV_NONE;
        if (det) begin
            ev = bit_v ? EV_ONES : EV_ZEROS;
        end
        return ev;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter. cnt_nxt is the value including this cycle's increment,
// so a window close can report it while the register itself is cleared.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt_nxt
);

    localparam logic [W-1:0] CNT_MAX = '1;

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Increment unless already at the ceiling; clear has priority for the stored value.
    always_comb begin
        cnt_nxt = cnt_q;
        if (inc && (cnt_q != CNT_MAX)) begin
            cnt_nxt = cnt_q + 1'b1;
        end
        cnt_d = clr ? '0 : cnt_nxt;
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/run_event_counter.sv
// Windowed 111/000 event accumulator with a single-entry valid/ready report
// register and a sticky loss flag.
//
// state | meaning
// IDLE  | no window open; waiting for the first bit cycle
// RUN   | window open, counting bit cycles and events
module run_event_counter
    import run_evt_pkg::*;
#(
    parameter int CW     = 8,
    parameter int WIN_W  = 9,
    parameter int WINDOW = 300
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             bit_in,
    input  logic             det_in,
    input  logic             flush,
    input  logic             rpt_ready,
    output logic             rpt_valid,
    output logic [CW-1:0]    ones_cnt,
    output logic [CW-1:0]    zeros_cnt,
    output logic [WIN_W-1:0] rpt_len,
    output logic             drop,
    output logic             busy
);

    localparam logic [WIN_W-1:0] WIN_LEN = WIN_W'(WINDOW);

    state_e            state_q, state_d;
    logic [WIN_W-1:0]  bit_cnt_q, bit_cnt_d, bits_now;
    ev_t               ev;
    logic              ones_inc, zeros_inc;
    logic              full_close, flush_close, close, load;
    logic [CW-1:0]     ones_nxt, zeros_nxt;

    logic              rpt_valid_q, rpt_valid_d;
    logic [CW-1:0]     ones_rpt_q, ones_rpt_d;
    logic [CW-1:0]     zeros_rpt_q, zeros_rpt_d;
    logic [WIN_W-1:0]  len_rpt_q, len_rpt_d;
    logic              drop_q, drop_d;

    // Classify this cycle's event and detect window closes. bits_now already
    // includes the current bit cycle, so it doubles as the reported length.
    always_comb begin
        ev          = en ? classify(det_in, bit_in) : EV_NONE;
        ones_inc    = (ev == EV_ONES);
        zeros_inc   = (ev == EV_ZEROS);
        bits_now    = bit_cnt_q + {{(WIN_W-1){1'b0}}, en};
        full_close  = en && (bits_now == WIN_LEN);
        flush_close = (state_q == RUN) && flush && (bits_now != '0);
        close       = full_close || flush_close;
        bit_cnt_d   = close ? '0 : bits_now;
    end

    sat_counter #(.W(CW)) u_ones_acc (
        .clk     (clk),
        .rst     (rst),
        .inc     (ones_inc),
        .clr     (close),
        .cnt_nxt (ones_nxt)
    );

    sat_counter #(.W(CW)) u_zeros_acc (
        .clk     (clk),
        .rst     (rst),
        .inc     (zeros_inc),
        .clr     (close),
        .cnt_nxt (zeros_nxt)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: open on the first bit cycle, leave only on flush.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (en)    state_d = RUN;
            RUN:     if (flush) state_d = IDLE;
            default:            state_d = IDLE;
        endcase
    end

    // FSM output: busy comes straight from the state register.
    always_comb begin
        busy = (state_q == RUN);
    end

    // Report holding register: load on close when empty or draining this
    // cycle, otherwise a close is lost and flagged.
    always_comb begin
        load        = close && (!rpt_valid_q || rpt_ready);
        rpt_valid_d = rpt_valid_q;
        ones_rpt_d  = ones_rpt_q;
        zeros_rpt_d = zeros_rpt_q;
        len_rpt_d   = len_rpt_q;
        drop_d      = drop_q | (close && rpt_valid_q && !rpt_ready);
        if (load) begin
            rpt_valid_d = 1'b1;
            ones_rpt_d  = ones_nxt;
            zeros_rpt_d = zeros_nxt;
            len_rpt_d   = bits_now;
        end else if (rpt_ready) begin
            rpt_valid_d = 1'b0;
        end
    end

    // Window bit counter and report registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt_q   <= '0;
            rpt_valid_q <= 1'b0;
            ones_rpt_q  <= '0;
            zeros_rpt_q <= '0;
            len_rpt_q   <= '0;
            drop_q      <= 1'b0;
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            rpt_valid_q <= rpt_valid_d;
            ones_rpt_q  <= ones_rpt_d;
            zeros_rpt_q <= zeros_rpt_d;
            len_rpt_q   <= len_rpt_d;
            drop_q      <= drop_d;
        end
    end

    assign rpt_valid = rpt_valid_q;
    assign ones_cnt  = ones_rpt_q;
    assign zeros_cnt = zeros_rpt_q;
    assign rpt_len   = len_rpt_q;
    assign drop      = drop_q;

endmodule

// File: tb/tb_run_event_counter.sv
// Bench for run_event_counter: a WINDOW=16 instance checked against a
// behavioural model and report scoreboard, plus a default-parameter instance
// for the saturation case.
module tb_run_event_counter;

    logic clk = 1'b0;
    logic rst, en, bit_in, det_in, flush, rpt_ready;

    logic       v16, drop16, busy16;
    logic [7:0] o16, z16;
    logic [8:0] len16;
    logic       v300, drop300, busy300;
    logic [7:0] o300, z300;
    logic [8:0] len300;

    run_event_counter #(.CW(8), .WIN_W(9), .WINDOW(16)) dut16 (
        .clk(clk), .rst(rst), .en(en), .bit_in(bit_in), .det_in(det_in),
        .flush(flush), .rpt_ready(rpt_ready), .rpt_valid(v16), .ones_cnt(o16),
        .zeros_cnt(z16), .rpt_len(len16), .drop(drop16), .busy(busy16)
    );

    run_event_counter dut300 (
        .clk(clk), .rst(rst), .en(en), .bit_in(bit_in), .det_in(det_in),
        .flush(flush), .rpt_ready(rpt_ready), .rpt_valid(v300), .ones_cnt(o300),
        .zeros_cnt(z300), .rpt_len(len300), .drop(drop300), .busy(busy300)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] o;
        logic [7:0] z;
        logic [8:0] len;
    } rpt_t;

    typedef struct {
        logic e, b, d, fl, rdy;
        int   ev, eo, ez, el, ebusy;
    } vec_t;

    int   total = 0;
    int   bad   = 0;
    rpt_t sb[$];
    vec_t tv[17];

    logic m_run, m_valid, m_drop;
    int   m_bits, m_ones, m_zeros;

    function automatic void chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    function automatic void model_clear();
        m_run = 1'b0; m_valid = 1'b0; m_drop = 1'b0;
        m_bits = 0; m_ones = 0; m_zeros = 0;
        sb.delete();
    endfunction

    // Behavioural reference for the WINDOW=16 instance.
    function automatic void model_step(input logic e, b, d, fl, rdy);
        int   o, z, bits;
        logic cls;
        rpt_t r;
        o    = m_ones  + ((e && d && b)  ? 1 : 0);
        z    = m_zeros + ((e && d && !b) ? 1 : 0);
        if (o > 255) o = 255;
        if (z > 255) z = 255;
        bits = m_bits + (e ? 1 : 0);
        cls  = (e && bits == 16) || (m_run && fl && bits != 0);
        if (cls) begin
            if (!m_valid || rdy) begin
                r.o = o[7:0]; r.z = z[7:0]; r.len = bits[8:0];
                sb.push_back(r);
                m_valid = 1'b1;
            end else begin
                m_drop = 1'b1;
            end
            m_ones = 0; m_zeros = 0; m_bits = 0;
        end else begin
            if (m_valid && rdy) m_valid = 1'b0;
            m_ones = o; m_zeros = z; m_bits = bits;
        end
        m_run = m_run ? !fl : e;
    endfunction

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; bit_in = 1'b0; det_in = 1'b0; flush = 1'b0; rpt_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
    endtask

    task automatic cyc(input logic e, b, d, fl, rdy);
        rpt_t r;
        en = e; bit_in = b; det_in = d; flush = fl; rpt_ready = rdy;
        if (v16 && rdy) begin
            if (sb.size() == 0) begin
                chk("xfer_sb_nonempty", sb.size(), 1);
            end else begin
                r = sb.pop_front();
                chk("xfer_ones", o16, r.o);
                chk("xfer_zeros", z16, r.z);
                chk("xfer_len", len16, r.len);
            end
        end
        model_step(e, b, d, fl, rdy);
        @(posedge clk); #1;
        chk("rpt_valid", v16, m_valid);
        chk("drop", drop16, m_drop);
        chk("busy", busy16, m_run);
        if (m_valid && sb.size() > 0) begin
            chk("hold_ones", o16, sb[0].o);
            chk("hold_zeros", z16, sb[0].z);
            chk("hold_len", len16, sb[0].len);
        end
    endtask

    task automatic apply_table(input string tag);
        for (int i = 0; i < 17; i++) begin
            cyc(tv[i].e, tv[i].b, tv[i].d, tv[i].fl, tv[i].rdy);
            chk({tag, "_valid"}, v16, tv[i].ev);
            chk({tag, "_ones"}, o16, tv[i].eo);
            chk({tag, "_zeros"}, z16, tv[i].ez);
            chk({tag, "_len"}, len16, tv[i].el);
            chk({tag, "_busy"}, busy16, tv[i].ebusy);
        end
    endtask

    initial begin
        logic [15:0] pat;
        logic [15:0] detp;
        pat  = 16'b1111_0000_1010_1010;
        detp = 16'b0011_0011_0000_0000;
        for (int i = 0; i < 16; i++) begin
            tv[i].e = 1'b1; tv[i].b = pat[15-i]; tv[i].d = detp[15-i];
            tv[i].fl = 1'b0; tv[i].rdy = 1'b0;
            tv[i].ev = (i == 15) ? 1 : 0;
            tv[i].eo = (i == 15) ? 2 : 0;
            tv[i].ez = (i == 15) ? 2 : 0;
            tv[i].el = (i == 15) ? 16 : 0;
            tv[i].ebusy = 1;
        end
        tv[16].e = 1'b0; tv[16].b = 1'b0; tv[16].d = 1'b0; tv[16].fl = 1'b0; tv[16].rdy = 1'b1;
        tv[16].ev = 0; tv[16].eo = 2; tv[16].ez = 2; tv[16].el = 16; tv[16].ebusy = 1;

        // reset state
        do_reset();
        chk("rst_valid", v16, 0);
        chk("rst_ones", o16, 0);
        chk("rst_len", len16, 0);
        chk("rst_drop", drop16, 0);
        chk("rst_busy", busy16, 0);
        chk("rst300_valid", v300, 0);

        // full window, mixed pattern
        apply_table("t1");

        // saturation on the default instance
        do_reset();
        for (int i = 0; i < 300; i++) cyc(1'b1, 1'b1, (i >= 2), 1'b0, 1'b0);
        chk("t2_valid", v300, 1);
        chk("t2_ones", o300, 255);
        chk("t2_zeros", z300, 0);
        chk("t2_len", len300, 300);
        chk("t2_drop", drop300, 0);

        // two closes with consumer stalled
        do_reset();
        for (int i = 0; i < 32; i++) begin
            cyc(1'b1, ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1), 1'b0, 1'b0);
            if (i == 15) chk("t3_drop_after_first", drop16, 0);
        end
        chk("t3_valid", v16, 1);
        chk("t3_drop", drop16, 1);
        chk("t3_len", len16, 16);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t3_valid_after_xfer", v16, 0);
        chk("t3_sb_empty", sb.size(), 0);

        // ready exactly on the second close
        do_reset();
        for (int i = 0; i < 32; i++)
            cyc(1'b1, ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1), 1'b0, (i == 31));
        chk("t4_valid", v16, 1);
        chk("t4_drop", drop16, 0);
        chk("t4_len", len16, 16);
        chk("t4_sb_one", sb.size(), 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // partial window flush, then a flush from IDLE
        do_reset();
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t5_valid", v16, 1);
        chk("t5_ones", o16, 1);
        chk("t5_zeros", z16, 0);
        chk("t5_len", len16, 5);
        chk("t5_busy", busy16, 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t5_second_flush_drop", drop16, 0);
        chk("t5_second_flush_sb", sb.size(), 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // flush on bit WINDOW, then flush right after a full close
        for (int i = 0; i < 15; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("t5b_len", len16, 16);
        chk("t5b_zeros", z16, 1);
        chk("t5b_busy", busy16, 0);
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("t5c_no_report", v16, 0);
        chk("t5c_busy", busy16, 0);

        // reset mid-window with a report pending
        do_reset();
        for (int i = 0; i < 21; i++)
            cyc(1'b1, ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1), 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("t6_valid", v16, 0);
        chk("t6_ones", o16, 0);
        chk("t6_zeros", z16, 0);
        chk("t6_len", len16, 0);
        chk("t6_drop", drop16, 0);
        chk("t6_busy", busy16, 0);
        rst = 1'b0;
        model_clear();
        apply_table("t6_fresh");

        // random traffic against the model
        do_reset();
        for (int i = 0; i < 400; i++)
            cyc(($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 1),
                ($urandom_range(0, 1) == 1), ($urandom_range(0, 19) == 0),
                ($urandom_range(0, 1) == 1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
